rs_alu_station: RTL and testbench

- 16-entry reservation station for the integer ALU.
- Accepts at most one dispatched instruction per cycle from the decoder/rename stage and places it in the lowest-index vacant entry.
- Snoops two CDB broadcast ports to resolve pending operands.
- Each cycle, issues the lowest-index entry with both operands ready to the ALU through a registered issue interface, then frees that entry.

---
 rtl/rs_alu_if.sv | 42 ++++
 rtl/rs_alu_station.sv | 137 +++++++++++++
 tb/tb_rs_alu_station.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_alu_if.sv
// rs_alu_if: dispatch, CDB snoop and issue bus of the ALU reservation station.
//   master = decoder/CDB/ALU side, slave = reservation station.
//   disp_*  : one instruction per cycle into the station, full_out back-pressure.
//   cdb0/1_*: result broadcasts used to resolve pending operands.
//   issue_* : registered operation handed to the ALU.
interface rs_alu_if #(
  parameter int ROB_TAG_W = 5,
  parameter int OP_W      = 5,
  parameter int XLEN      = 32
);
  logic                 disp_valid_in;
  logic [OP_W-1:0]      disp_op_in;
  logic [XLEN-1:0]      disp_vj_in;
  logic [XLEN-1:0]      disp_vk_in;
  logic [ROB_TAG_W-1:0] disp_qj_in;
  logic [ROB_TAG_W-1:0] disp_qk_in;
  logic [ROB_TAG_W-1:0] disp_dest_in;
  logic                 full_out;
  logic                 cdb0_valid_in;
  logic [ROB_TAG_W-1:0] cdb0_tag_in;
  logic [XLEN-1:0]      cdb0_value_in;
  logic                 cdb1_valid_in;
  logic [ROB_TAG_W-1:0] cdb1_tag_in;
  logic [XLEN-1:0]      cdb1_value_in;
  logic                 issue_valid_out;
  logic [OP_W-1:0]      issue_op_out;
  logic [XLEN-1:0]      issue_a_out;
  logic [XLEN-1:0]      issue_b_out;
  logic [ROB_TAG_W-1:0] issue_dest_out;
  modport master (
    output disp_valid_in, disp_op_in, disp_vj_in, disp_vk_in, disp_qj_in, disp_qk_in, disp_dest_in,
    input  full_out,
    output cdb0_valid_in, cdb0_tag_in, cdb0_value_in, cdb1_valid_in, cdb1_tag_in, cdb1_value_in,
    input  issue_valid_out, issue_op_out, issue_a_out, issue_b_out, issue_dest_out
  );
  modport slave (
    input  disp_valid_in, disp_op_in, disp_vj_in, disp_vk_in, disp_qj_in, disp_qk_in, disp_dest_in,
    output full_out,
    input  cdb0_valid_in, cdb0_tag_in, cdb0_value_in, cdb1_valid_in, cdb1_tag_in, cdb1_value_in,
    output issue_valid_out, issue_op_out, issue_a_out, issue_b_out, issue_dest_out
  );
endinterface

// File: rtl/rs_alu_station.sv
// rs_alu_station: 16-entry reservation station feeding the integer ALU.
//   clk_in   : rising-edge clock
//   rst_n_in : asynchronous active-low reset
//   rdy_in   : global enable, all state holds when low
//   flush_in : synchronous clear of every entry (mispredict)
//   bus      : rs_alu_if.slave carrying dispatch, two CDB snoop ports and issue
module rs_alu_station #(
  parameter int ROB_TAG_W = 5,
  parameter int OP_W      = 5,
  parameter int XLEN      = 32
) (
  input logic   clk_in,
  input logic   rst_n_in,
  input logic   rdy_in,
  input logic   flush_in,
  rs_alu_if.slave bus
);
  localparam int N  = 16;
  localparam int IW = 4;
  logic [N-1:0]         busy_q, busy_d;
  logic [OP_W-1:0]      op_q[N], op_d[N];
  logic [XLEN-1:0]      vj_q[N], vj_d[N], vk_q[N], vk_d[N];
  logic [ROB_TAG_W-1:0] qj_q[N], qj_d[N], qk_q[N], qk_d[N], dest_q[N], dest_d[N];
  logic                 iss_valid_q, iss_valid_d;
  logic [OP_W-1:0]      iss_op_q, iss_op_d;
  logic [XLEN-1:0]      iss_a_q, iss_a_d, iss_b_q, iss_b_d;
  logic [ROB_TAG_W-1:0] iss_dest_q, iss_dest_d;
  logic [IW-1:0]        free_idx, iss_idx;
  logic                 free_ok, iss_ok, iss_go;
  logic [XLEN:0]        sj, sk, dj, dk;
  // {hit, value} for a tag; tag 0 never matches and port 0 wins a double hit
  function automatic logic [XLEN:0] snoop(input logic [ROB_TAG_W-1:0] t);
    return (t != '0 && bus.cdb0_valid_in && bus.cdb0_tag_in == t) ? {1'b1, bus.cdb0_value_in} :
           (t != '0 && bus.cdb1_valid_in && bus.cdb1_tag_in == t) ? {1'b1, bus.cdb1_value_in} : '0;
  endfunction
  // Downward scan leaves the lowest-index vacant and lowest-index ready entry
  always_comb begin
    free_idx = '0;
    free_ok  = 1'b0;
    iss_idx  = '0;
    iss_ok   = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_idx = IW'(i);
        free_ok  = 1'b1;
      end
      if (busy_q[i] && qj_q[i] == '0 && qk_q[i] == '0) begin
        iss_idx = IW'(i);
        iss_ok  = 1'b1;
      end
    end
  end
  // Slot choice uses pre-edge busy, so dispatch never lands on the issuing entry
  always_comb begin
    busy_d = busy_q;
    op_d   = op_q;
    vj_d   = vj_q;
    vk_d   = vk_q;
    qj_d   = qj_q;
    qk_d   = qk_q;
    dest_d = dest_q;
    sj     = '0;
    sk     = '0;
    for (int i = 0; i < N; i++) begin
      sj = snoop(qj_q[i]);
      sk = snoop(qk_q[i]);
      if (busy_q[i] && sj[XLEN]) begin
        vj_d[i] = sj[XLEN-1:0];
        qj_d[i] = '0;
      end
      if (busy_q[i] && sk[XLEN]) begin
        vk_d[i] = sk[XLEN-1:0];
        qk_d[i] = '0;
      end
    end
    if (iss_ok) busy_d[iss_idx] = 1'b0;
    dj = snoop(bus.disp_qj_in);
    dk = snoop(bus.disp_qk_in);
    if (bus.disp_valid_in && free_ok) begin
      busy_d[free_idx] = 1'b1;
      op_d[free_idx]   = bus.disp_op_in;
      dest_d[free_idx] = bus.disp_dest_in;
      vj_d[free_idx]   = dj[XLEN] ? dj[XLEN-1:0] : bus.disp_vj_in;
      qj_d[free_idx]   = dj[XLEN] ? '0 : bus.disp_qj_in;
      vk_d[free_idx]   = dk[XLEN] ? dk[XLEN-1:0] : bus.disp_vk_in;
      qk_d[free_idx]   = dk[XLEN] ? '0 : bus.disp_qk_in;
    end
    if (flush_in) busy_d = '0;
  end
  assign iss_go      = iss_ok && !flush_in;
  assign iss_valid_d = iss_go;
  assign iss_op_d    = iss_go ? op_q[iss_idx]   : iss_op_q;
  assign iss_a_d     = iss_go ? vj_q[iss_idx]   : iss_a_q;
  assign iss_b_d     = iss_go ? vk_q[iss_idx]   : iss_b_q;
  assign iss_dest_d  = iss_go ? dest_q[iss_idx] : iss_dest_q;
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_q      <= '0;
      iss_valid_q <= 1'b0;
      iss_op_q    <= '0;
      iss_a_q     <= '0;
      iss_b_q     <= '0;
      iss_dest_q  <= '0;
      for (int i = 0; i < N; i++) begin
        op_q[i]   <= '0;
        vj_q[i]   <= '0;
        vk_q[i]   <= '0;
        qj_q[i]   <= '0;
        qk_q[i]   <= '0;
        dest_q[i] <= '0;
      end
    end else if (rdy_in) begin
      busy_q      <= busy_d;
      op_q        <= op_d;
      vj_q        <= vj_d;
      vk_q        <= vk_d;
      qj_q        <= qj_d;
      qk_q        <= qk_d;
      dest_q      <= dest_d;
      iss_valid_q <= iss_valid_d;
      iss_op_q    <= iss_op_d;
      iss_a_q     <= iss_a_d;
      iss_b_q     <= iss_b_d;
      iss_dest_q  <= iss_dest_d;
    end
  end
  assign bus.full_out        = &busy_q;
  assign bus.issue_valid_out = iss_valid_q;
  assign bus.issue_op_out    = iss_op_q;
  assign bus.issue_a_out     = iss_a_q;
  assign bus.issue_b_out     = iss_b_q;
  assign bus.issue_dest_out  = iss_dest_q;
  a_no_disp_when_full: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    !(rdy_in && bus.disp_valid_in && bus.full_out));
  a_no_dup_cdb_tag: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    !(rdy_in && bus.cdb0_valid_in && bus.cdb1_valid_in && bus.cdb0_tag_in != '0 && bus.cdb0_tag_in == bus.cdb1_tag_in));
endmodule

// File: tb/tb_rs_alu_station.sv
// tb_rs_alu_station: scoreboard bench for rs_alu_station with an entry-array reference model.
module tb_rs_alu_station;
  localparam int TW = 5;
  localparam int OW = 5;
  localparam int XL = 32;
  localparam int N  = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;
  rs_alu_if #(.ROB_TAG_W(TW), .OP_W(OW), .XLEN(XL)) bus();
  rs_alu_station #(.ROB_TAG_W(TW), .OP_W(OW), .XLEN(XL)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .flush_in(flush), .bus(bus)
  );
  typedef struct {
    bit busy;
    logic [OW-1:0] op;
    logic [XL-1:0] vj, vk;
    logic [TW-1:0] qj, qk, dest;
  } ent_t;
  typedef struct {
    int cyc;
    logic [OW-1:0] op;
    logic [XL-1:0] a, b;
    logic [TW-1:0] dest;
  } exp_t;
  ent_t m[N];
  exp_t sb[$];
  exp_t e;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  bit en_q = 1'b0;
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    en_q <= rst_n && rdy;
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic int mcount();
    int c = 0;
    foreach (m[i]) if (m[i].busy) c++;
    return c;
  endfunction
  function automatic logic [XL:0] msnoop(input logic [TW-1:0] t);
    if (t == 0) return '0;
    if (bus.cdb0_valid_in && bus.cdb0_tag_in == t) return {1'b1, bus.cdb0_value_in};
    if (bus.cdb1_valid_in && bus.cdb1_tag_in == t) return {1'b1, bus.cdb1_value_in};
    return '0;
  endfunction
  task automatic mclear();
    foreach (m[i]) m[i].busy = 0;
  endtask
  // Applies the coming edge to the model; predicted issues go to the scoreboard
  task automatic model_step();
    int fi = -1;
    int ii = -1;
    logic [XL:0] s;
    if (!rdy || !rst_n) return;
    if (flush) begin
      mclear();
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (fi < 0 && !m[i].busy) fi = i;
      if (ii < 0 && m[i].busy && m[i].qj == 0 && m[i].qk == 0) ii = i;
    end
    if (ii >= 0) begin
      sb.push_back('{cyc + 1, m[ii].op, m[ii].vj, m[ii].vk, m[ii].dest});
      m[ii].busy = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (!m[i].busy) continue;
      s = msnoop(m[i].qj);
      if (s[XL]) begin m[i].vj = s[XL-1:0]; m[i].qj = 0; end
      s = msnoop(m[i].qk);
      if (s[XL]) begin m[i].vk = s[XL-1:0]; m[i].qk = 0; end
    end
    if (bus.disp_valid_in && fi >= 0) begin
      m[fi].busy = 1;
      m[fi].op   = bus.disp_op_in;
      m[fi].dest = bus.disp_dest_in;
      s = msnoop(bus.disp_qj_in);
      m[fi].vj = s[XL] ? s[XL-1:0] : bus.disp_vj_in;
      m[fi].qj = s[XL] ? '0 : bus.disp_qj_in;
      s = msnoop(bus.disp_qk_in);
      m[fi].vk = s[XL] ? s[XL-1:0] : bus.disp_vk_in;
      m[fi].qk = s[XL] ? '0 : bus.disp_qk_in;
    end
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      chk("full", bus.full_out, mcount() == N);
      if (en_q) begin
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
          e = sb.pop_front();
          chk("iss_valid", bus.issue_valid_out, 1);
          chk("iss_op", bus.issue_op_out, e.op);
          chk("iss_a", bus.issue_a_out, e.a);
          chk("iss_b", bus.issue_b_out, e.b);
          chk("iss_dest", bus.issue_dest_out, e.dest);
        end else begin
          chk("noissue", bus.issue_valid_out, 0);
        end
      end
    end
  end
  task automatic idle();
    rdy = 1;
    flush = 0;
    bus.disp_valid_in = 0;
    bus.disp_op_in = '0;
    bus.disp_vj_in = '0;
    bus.disp_vk_in = '0;
    bus.disp_qj_in = '0;
    bus.disp_qk_in = '0;
    bus.disp_dest_in = '0;
    bus.cdb0_valid_in = 0;
    bus.cdb0_tag_in = '0;
    bus.cdb0_value_in = '0;
    bus.cdb1_valid_in = 0;
    bus.cdb1_tag_in = '0;
    bus.cdb1_value_in = '0;
  endtask
  task automatic disp(input logic [OW-1:0] op, input logic [XL-1:0] vj, input logic [XL-1:0] vk,
                      input logic [TW-1:0] qj, input logic [TW-1:0] qk, input logic [TW-1:0] dest);
    bus.disp_valid_in = 1;
    bus.disp_op_in = op;
    bus.disp_vj_in = vj;
    bus.disp_vk_in = vk;
    bus.disp_qj_in = qj;
    bus.disp_qk_in = qk;
    bus.disp_dest_in = dest;
  endtask
  task automatic cdb(input int port, input logic [TW-1:0] tag, input logic [XL-1:0] val);
    if (port == 0) begin
      bus.cdb0_valid_in = 1; bus.cdb0_tag_in = tag; bus.cdb0_value_in = val;
    end else begin
      bus.cdb1_valid_in = 1; bus.cdb1_tag_in = tag; bus.cdb1_value_in = val;
    end
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    #1;
    idle();
  endtask
  task automatic chk_reset_outputs(input string tagname);
    chk({tagname, "_valid"}, bus.issue_valid_out, 0);
    chk({tagname, "_op"}, bus.issue_op_out, 0);
    chk({tagname, "_a"}, bus.issue_a_out, 0);
    chk({tagname, "_b"}, bus.issue_b_out, 0);
    chk({tagname, "_dest"}, bus.issue_dest_out, 0);
    chk({tagname, "_full"}, bus.full_out, 0);
  endtask
  initial begin
    idle();
    mclear();
    @(negedge clk);
    #1;
    chk_reset_outputs("rst");
    rst_n = 1;
    // ready dispatch issues one edge later, then the slot is free again
    disp(3, 5, 7, 0, 0, 9);
    repeat (3) tick();
    // operand j resolved by cdb1 two cycles after dispatch
    disp(1, 0, 22, 4, 0, 10);
    tick();
    tick();
    cdb(1, 4, 32'h1234);
    repeat (3) tick();
    // capture bypass from cdb0 in the dispatch cycle
    disp(2, 0, 33, 6, 0, 11);
    cdb(0, 6, 32'hAA);
    repeat (3) tick();
    // fill every entry behind tag 3, then release them all at once
    for (int i = 0; i < N; i++) begin
      disp(4, i, 100 + i, 3, 0, TW'(i + 1));
      tick();
    end
    chk("full16", bus.full_out, 1);
    cdb(0, 3, 32'h77);
    repeat (N + 2) tick();
    // flush beats concurrent dispatch and wakeup
    for (int i = 0; i < 5; i++) begin
      disp(5, i, i, 7, 0, TW'(20 + i));
      tick();
    end
    flush = 1;
    disp(6, 1, 2, 0, 0, 30);
    cdb(0, 7, 32'h99);
    tick();
    chk("flush_valid", bus.issue_valid_out, 0);
    chk("flush_full", bus.full_out, 0);
    cdb(1, 7, 32'h98);
    repeat (3) tick();
    // rdy low freezes outputs and ignores dispatch and CDB
    disp(7, 1, 2, 5, 0, 14);
    tick();
    disp(8, 32'h111, 32'h222, 0, 0, 12);
    tick();
    disp(9, 32'h333, 32'h444, 0, 0, 13);
    tick();
    for (int i = 0; i < 3; i++) begin
      rdy = 0;
      cdb(0, 5, 32'h55);
      disp(10, 9, 9, 0, 0, 15);
      tick();
      chk("frz_valid", bus.issue_valid_out, 1);
      chk("frz_a", bus.issue_a_out, 32'h111);
      chk("frz_dest", bus.issue_dest_out, 12);
    end
    repeat (3) tick();
    cdb(1, 5, 32'h5A5A);
    repeat (3) tick();
    // randomized traffic with one asynchronous reset in the middle
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) begin
        rst_n = 0;
        #1;
        mclear();
        sb.delete();
        chk_reset_outputs("midrst");
        @(negedge clk);
        #1;
        rst_n = 1;
      end
      rdy = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 99) == 0);
      if (mcount() < N && $urandom_range(0, 2) != 0)
        disp(OW'($urandom_range(0, 31)), $urandom, $urandom,
             $urandom_range(0, 1) ? TW'(0) : TW'($urandom_range(1, 7)),
             $urandom_range(0, 1) ? TW'(0) : TW'($urandom_range(1, 7)),
             TW'($urandom_range(1, 31)));
      if ($urandom_range(0, 1)) cdb(0, TW'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 1)) begin
        logic [TW-1:0] t1;
        t1 = TW'($urandom_range(0, 7));
        if (bus.cdb0_valid_in && t1 == bus.cdb0_tag_in) t1 = 0;
        cdb(1, t1, $urandom);
      end
      tick();
    end
    for (int t = 1; t < 8; t++) begin
      cdb(0, TW'(t), 32'hC0DE0000 + t);
      tick();
    end
    repeat (N + 2) tick();
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
